// File: rtl/stopwatch_ctrl.sv
// Stopwatch front-panel controller: button edge detection, run/pause/set/load FSM and lap capture.
// Optional lap capture is built in when STOPWATCH_CTRL_LAP_EN is defined.
module stopwatch_ctrl #(
  parameter int unsigned TIMESET_CYCLES = 2
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       btn_ss_i,
  input  logic       btn_lap_i,
  input  logic       btn_mode_i,
  input  logic       btn_inc_i,
  input  logic [5:0] sec_i,
  input  logic [5:0] min_i,
  input  logic [4:0] hour_i,
  output logic       start_stop,
  output logic       Timeset,
  output logic [4:0] Hourset,
  output logic [5:0] Minset,
  output logic [5:0] Secset,
  output logic [4:0] lap_hour_o,
  output logic [5:0] lap_min_o,
  output logic [5:0] lap_sec_o,
  output logic [2:0] state_o,
  output logic [1:0] sel_o
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_PAUSE = 3'd2,
    S_SET   = 3'd3,
    S_LOAD  = 3'd4
  } state_t;

  localparam logic [3:0] LP_CYC = 4'(TIMESET_CYCLES);

  state_t     r_state;
  logic [3:0] r_cnt;
  logic [1:0] r_sel;
  logic       r_start_stop;
  logic       r_timeset;
  logic [4:0] r_hour_sh;
  logic [5:0] r_min_sh;
  logic [5:0] r_sec_sh;
  logic       r_ss_d, r_lap_d, r_mode_d, r_inc_d;

  logic w_ss_e, w_lap_e, w_mode_e, w_inc_e;
  logic w_ev_ss, w_ev_lap, w_ev_mode, w_ev_inc;

  function automatic logic [4:0] inc_hour(input logic [4:0] v);
    return (v >= 5'd23) ? 5'd0 : v + 5'd1;
  endfunction

  function automatic logic [5:0] inc_60(input logic [5:0] v);
    return (v >= 6'd59) ? 6'd0 : v + 6'd1;
  endfunction

  assign w_ss_e   = btn_ss_i   & ~r_ss_d;
  assign w_lap_e  = btn_lap_i  & ~r_lap_d;
  assign w_mode_e = btn_mode_i & ~r_mode_d;
  assign w_inc_e  = btn_inc_i  & ~r_inc_d;

  // Only the highest-priority edge survives: ss > lap > mode > inc.
  assign w_ev_ss   = w_ss_e;
  assign w_ev_lap  = w_lap_e  & ~w_ss_e;
  assign w_ev_mode = w_mode_e & ~w_ss_e & ~w_lap_e;
  assign w_ev_inc  = w_inc_e  & ~w_ss_e & ~w_lap_e & ~w_mode_e;

`ifdef STOPWATCH_CTRL_LAP_EN
  logic [4:0] r_lap_hour;
  logic [5:0] r_lap_min;
  logic [5:0] r_lap_sec;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_lap_hour <= '0;
      r_lap_min  <= '0;
      r_lap_sec  <= '0;
    end else if (r_state == S_RUN && w_ev_lap) begin
      r_lap_hour <= hour_i;
      r_lap_min  <= min_i;
      r_lap_sec  <= sec_i;
    end
  end

  assign lap_hour_o = r_lap_hour;
  assign lap_min_o  = r_lap_min;
  assign lap_sec_o  = r_lap_sec;
`else
  assign lap_hour_o = '0;
  assign lap_min_o  = '0;
  assign lap_sec_o  = '0;
`endif

  // Delay registers reset high so a button held through reset needs a fresh press.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_sel        <= '0;
      r_start_stop <= 1'b0;
      r_timeset    <= 1'b0;
      r_hour_sh    <= '0;
      r_min_sh     <= '0;
      r_sec_sh     <= '0;
      r_ss_d       <= 1'b1;
      r_lap_d      <= 1'b1;
      r_mode_d     <= 1'b1;
      r_inc_d      <= 1'b1;
    end else begin
      r_ss_d   <= btn_ss_i;
      r_lap_d  <= btn_lap_i;
      r_mode_d <= btn_mode_i;
      r_inc_d  <= btn_inc_i;
      case (r_state)
        S_IDLE: begin
          if (w_ev_ss) begin
            r_state      <= S_RUN;
            r_start_stop <= 1'b1;
          end else if (w_ev_mode) begin
            r_state   <= S_SET;
            r_sel     <= 2'd0;
            r_hour_sh <= hour_i;
            r_min_sh  <= min_i;
            r_sec_sh  <= sec_i;
          end
        end
        S_RUN: begin
          if (w_ev_ss) begin
            r_state      <= S_PAUSE;
            r_start_stop <= 1'b0;
          end
        end
        S_PAUSE: begin
          if (w_ev_ss) begin
            r_state      <= S_RUN;
            r_start_stop <= 1'b1;
          end else if (w_ev_lap) begin
            r_state   <= S_LOAD;
            r_cnt     <= '0;
            r_hour_sh <= '0;
            r_min_sh  <= '0;
            r_sec_sh  <= '0;
          end else if (w_ev_mode) begin
            r_state   <= S_SET;
            r_sel     <= 2'd0;
            r_hour_sh <= hour_i;
            r_min_sh  <= min_i;
            r_sec_sh  <= sec_i;
          end
        end
        S_SET: begin
          if (w_ev_mode) begin
            if (r_sel == 2'd2) begin
              r_state <= S_LOAD;
              r_sel   <= 2'd0;
              r_cnt   <= '0;
            end else begin
              r_sel <= r_sel + 2'd1;
            end
          end else if (w_ev_inc) begin
            case (r_sel)
              2'd0:    r_hour_sh <= inc_hour(r_hour_sh);
              2'd1:    r_min_sh  <= inc_60(r_min_sh);
              default: r_sec_sh  <= inc_60(r_sec_sh);
            endcase
          end
        end
        S_LOAD: begin
          // Strobe rises the cycle after entry and lasts LP_CYC cycles.
          if (r_cnt == LP_CYC) begin
            r_timeset <= 1'b0;
            r_cnt     <= '0;
            r_state   <= S_IDLE;
          end else begin
            r_timeset <= 1'b1;
            r_cnt     <= r_cnt + 4'd1;
          end
        end
        default: begin
          r_state      <= S_IDLE;
          r_start_stop <= 1'b0;
          r_timeset    <= 1'b0;
          r_sel        <= '0;
          r_cnt        <= '0;
        end
      endcase
    end
  end

  assign start_stop = r_start_stop;
  assign Timeset    = r_timeset;
  assign Hourset    = r_hour_sh;
  assign Minset     = r_min_sh;
  assign Secset     = r_sec_sh;
  assign state_o    = r_state;
  assign sel_o      = r_sel;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: vector table through a scoreboard queue plus reset corner sequences.
module tb_stopwatch_ctrl;

`ifdef STOPWATCH_CTRL_LAP_EN
  localparam bit LAP_EN = 1'b1;
`else
  localparam bit LAP_EN = 1'b0;
`endif

  localparam logic [3:0] B_NO  = 4'b0000;
  localparam logic [3:0] B_SS  = 4'b1000;
  localparam logic [3:0] B_LAP = 4'b0100;
  localparam logic [3:0] B_MD  = 4'b0010;
  localparam logic [3:0] B_IN  = 4'b0001;

  logic       clk = 1'b0;
  logic       reset_i;
  logic       btn_ss_i, btn_lap_i, btn_mode_i, btn_inc_i;
  logic [5:0] sec_i, min_i;
  logic [4:0] hour_i;
  logic       start_stop, Timeset;
  logic [4:0] Hourset, lap_hour_o;
  logic [5:0] Minset, Secset, lap_min_o, lap_sec_o;
  logic [2:0] state_o;
  logic [1:0] sel_o;

  int n_checks = 0;
  int n_fail   = 0;

  stopwatch_ctrl #(.TIMESET_CYCLES(2)) dut (
    .clk_i(clk), .reset_i(reset_i),
    .btn_ss_i(btn_ss_i), .btn_lap_i(btn_lap_i), .btn_mode_i(btn_mode_i), .btn_inc_i(btn_inc_i),
    .sec_i(sec_i), .min_i(min_i), .hour_i(hour_i),
    .start_stop(start_stop), .Timeset(Timeset),
    .Hourset(Hourset), .Minset(Minset), .Secset(Secset),
    .lap_hour_o(lap_hour_o), .lap_min_o(lap_min_o), .lap_sec_o(lap_sec_o),
    .state_o(state_o), .sel_o(sel_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      nm;
    logic [3:0] btn;
    logic [4:0] hr;
    logic [5:0] mn;
    logic [5:0] sc;
    logic [2:0] st;
    logic       so;
    logic       ts;
    logic [1:0] sel;
    logic [4:0] hs;
    logic [5:0] ms;
    logic [5:0] ss;
    logic [4:0] lh;
    logic [5:0] lm;
    logic [5:0] ls;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];

  function automatic vec_t mk(string nm, logic [3:0] btn, logic [4:0] hr, logic [5:0] mn,
                              logic [5:0] sc, logic [2:0] st, logic so, logic ts, logic [1:0] sel,
                              logic [4:0] hs, logic [5:0] ms, logic [5:0] ss, logic lapv);
    vec_t v;
    v.nm = nm; v.btn = btn; v.hr = hr; v.mn = mn; v.sc = sc;
    v.st = st; v.so = so; v.ts = ts; v.sel = sel;
    v.hs = hs; v.ms = ms; v.ss = ss;
    v.lh = (lapv && LAP_EN) ? 5'd1 : 5'd0;
    v.lm = (lapv && LAP_EN) ? 6'd2 : 6'd0;
    v.ls = (lapv && LAP_EN) ? 6'd3 : 6'd0;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic drive_btn(input logic [3:0] b);
    {btn_ss_i, btn_lap_i, btn_mode_i, btn_inc_i} = b;
  endtask

  task automatic step(input logic [3:0] b);
    drive_btn(b);
    @(posedge clk);
    #1;
  endtask

  // Run enable and load strobe must never overlap.
  always @(negedge clk) begin
    if (reset_i === 1'b0) begin
      n_checks++;
      if (start_stop && Timeset) begin
        n_fail++;
        $display("FAIL excl: start_stop=%0b Timeset=%0b required not both 1", start_stop, Timeset);
      end
    end
  end

  initial begin
    vec_t e;
    reset_i = 1'b1;
    drive_btn(B_NO);
    hour_i = 5'd0; min_i = 6'd0; sec_i = 6'd0;

    // Segment A: run, lap, pause
    tbl.push_back(mk("A_ss_run",   B_SS,  1, 2, 3, 1, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk("A_rel",      B_NO,  1, 2, 3, 1, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk("A_lap",      B_LAP, 1, 2, 3, 1, 1, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk("A_rel2",     B_NO,  1, 2, 3, 1, 1, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk("A_ss_pause", B_SS,  1, 2, 3, 2, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk("A_rel3",     B_NO,  1, 2, 3, 2, 0, 0, 0, 0, 0, 0, 1));
    // Segment B: set from pause, edit hour and minute, load
    tbl.push_back(mk("B_mode",     B_MD,  1, 2, 3, 3, 0, 0, 0, 1, 2, 3, 1));
    tbl.push_back(mk("B_rel",      B_NO,  1, 2, 3, 3, 0, 0, 0, 1, 2, 3, 1));
    tbl.push_back(mk("B_inc_h",    B_IN,  1, 2, 3, 3, 0, 0, 0, 2, 2, 3, 1));
    tbl.push_back(mk("B_rel2",     B_NO,  1, 2, 3, 3, 0, 0, 0, 2, 2, 3, 1));
    tbl.push_back(mk("B_mode1",    B_MD,  1, 2, 3, 3, 0, 0, 1, 2, 2, 3, 1));
    tbl.push_back(mk("B_rel3",     B_NO,  1, 2, 3, 3, 0, 0, 1, 2, 2, 3, 1));
    tbl.push_back(mk("B_inc_m",    B_IN,  1, 2, 3, 3, 0, 0, 1, 2, 3, 3, 1));
    tbl.push_back(mk("B_rel4",     B_NO,  1, 2, 3, 3, 0, 0, 1, 2, 3, 3, 1));
    tbl.push_back(mk("B_mode2",    B_MD,  1, 2, 3, 3, 0, 0, 2, 2, 3, 3, 1));
    tbl.push_back(mk("B_rel5",     B_NO,  1, 2, 3, 3, 0, 0, 2, 2, 3, 3, 1));
    tbl.push_back(mk("B_to_load",  B_MD,  1, 2, 3, 4, 0, 0, 0, 2, 3, 3, 1));
    tbl.push_back(mk("B_ts1",      B_NO,  1, 2, 3, 4, 0, 1, 0, 2, 3, 3, 1));
    tbl.push_back(mk("B_ts2",      B_NO,  1, 2, 3, 4, 0, 1, 0, 2, 3, 3, 1));
    tbl.push_back(mk("B_idle",     B_NO,  1, 2, 3, 0, 0, 0, 0, 2, 3, 3, 1));
    // Segment C: ss+lap priority in pause, mode ignored in run, lap-clear load
    tbl.push_back(mk("C_ss_run",   B_SS,  7, 8, 9, 1, 1, 0, 0, 2, 3, 3, 1));
    tbl.push_back(mk("C_rel",      B_NO,  7, 8, 9, 1, 1, 0, 0, 2, 3, 3, 1));
    tbl.push_back(mk("C_ss_pause", B_SS,  7, 8, 9, 2, 0, 0, 0, 2, 3, 3, 1));
    tbl.push_back(mk("C_rel2",     B_NO,  7, 8, 9, 2, 0, 0, 0, 2, 3, 3, 1));
    tbl.push_back(mk("C_ss_lap",   B_SS | B_LAP, 7, 8, 9, 1, 1, 0, 0, 2, 3, 3, 1));
    tbl.push_back(mk("C_rel3",     B_NO,  7, 8, 9, 1, 1, 0, 0, 2, 3, 3, 1));
    tbl.push_back(mk("C_mode_run", B_MD,  7, 8, 9, 1, 1, 0, 0, 2, 3, 3, 1));
    tbl.push_back(mk("C_rel4",     B_NO,  7, 8, 9, 1, 1, 0, 0, 2, 3, 3, 1));
    tbl.push_back(mk("C_ss_pause2",B_SS,  7, 8, 9, 2, 0, 0, 0, 2, 3, 3, 1));
    tbl.push_back(mk("C_rel5",     B_NO,  7, 8, 9, 2, 0, 0, 0, 2, 3, 3, 1));
    tbl.push_back(mk("C_lap_clr",  B_LAP, 7, 8, 9, 4, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk("C_ts1",      B_NO,  7, 8, 9, 4, 0, 1, 0, 0, 0, 0, 1));
    tbl.push_back(mk("C_ts2_ss",   B_SS,  7, 8, 9, 4, 0, 1, 0, 0, 0, 0, 1));
    tbl.push_back(mk("C_idle",     B_NO,  7, 8, 9, 0, 0, 0, 0, 0, 0, 0, 1));
    // Segment D: set from idle at 23:59:58 with wrap on every field
    tbl.push_back(mk("D_mode",     B_MD, 23, 59, 58, 3, 0, 0, 0, 23, 59, 58, 1));
    tbl.push_back(mk("D_rel",      B_NO, 23, 59, 58, 3, 0, 0, 0, 23, 59, 58, 1));
    tbl.push_back(mk("D_inc_h",    B_IN, 23, 59, 58, 3, 0, 0, 0,  0, 59, 58, 1));
    tbl.push_back(mk("D_rel2",     B_NO, 23, 59, 58, 3, 0, 0, 0,  0, 59, 58, 1));
    tbl.push_back(mk("D_mode1",    B_MD, 23, 59, 58, 3, 0, 0, 1,  0, 59, 58, 1));
    tbl.push_back(mk("D_rel3",     B_NO, 23, 59, 58, 3, 0, 0, 1,  0, 59, 58, 1));
    tbl.push_back(mk("D_inc_m",    B_IN, 23, 59, 58, 3, 0, 0, 1,  0,  0, 58, 1));
    tbl.push_back(mk("D_rel4",     B_NO, 23, 59, 58, 3, 0, 0, 1,  0,  0, 58, 1));
    tbl.push_back(mk("D_mode_inc", B_MD | B_IN, 23, 59, 58, 3, 0, 0, 2, 0, 0, 58, 1));
    tbl.push_back(mk("D_rel5",     B_NO, 23, 59, 58, 3, 0, 0, 2,  0,  0, 58, 1));
    tbl.push_back(mk("D_inc_s1",   B_IN, 23, 59, 58, 3, 0, 0, 2,  0,  0, 59, 1));
    tbl.push_back(mk("D_rel6",     B_NO, 23, 59, 58, 3, 0, 0, 2,  0,  0, 59, 1));
    tbl.push_back(mk("D_inc_s2",   B_IN, 23, 59, 58, 3, 0, 0, 2,  0,  0,  0, 1));
    tbl.push_back(mk("D_rel7",     B_NO, 23, 59, 58, 3, 0, 0, 2,  0,  0,  0, 1));
    tbl.push_back(mk("D_to_load",  B_MD, 23, 59, 58, 4, 0, 0, 0,  0,  0,  0, 1));
    tbl.push_back(mk("D_ts1",      B_NO, 23, 59, 58, 4, 0, 1, 0,  0,  0,  0, 1));
    tbl.push_back(mk("D_ts2",      B_NO, 23, 59, 58, 4, 0, 1, 0,  0,  0,  0, 1));
    tbl.push_back(mk("D_idle",     B_NO, 23, 59, 58, 0, 0, 0, 0,  0,  0,  0, 1));

    repeat (2) @(posedge clk);
    #1;
    chk("rst_state", state_o, 0);
    chk("rst_ss",    start_stop, 0);
    chk("rst_ts",    Timeset, 0);
    chk("rst_sel",   sel_o, 0);
    chk("rst_shadow", {Hourset, Minset, Secset}, 0);
    chk("rst_lap",   {lap_hour_o, lap_min_o, lap_sec_o}, 0);
    reset_i = 1'b0;
    step(B_NO);

    foreach (tbl[i]) begin
      drive_btn(tbl[i].btn);
      hour_i = tbl[i].hr; min_i = tbl[i].mn; sec_i = tbl[i].sc;
      sb.push_back(tbl[i]);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      chk({e.nm, "_state"}, state_o, e.st);
      chk({e.nm, "_ss"},    start_stop, e.so);
      chk({e.nm, "_ts"},    Timeset, e.ts);
      chk({e.nm, "_sel"},   sel_o, e.sel);
      chk({e.nm, "_hset"},  Hourset, e.hs);
      chk({e.nm, "_mset"},  Minset, e.ms);
      chk({e.nm, "_sset"},  Secset, e.ss);
      chk({e.nm, "_laph"},  lap_hour_o, e.lh);
      chk({e.nm, "_lapm"},  lap_min_o, e.lm);
      chk({e.nm, "_laps"},  lap_sec_o, e.ls);
    end

    // Button held across reset release must not start the watch.
    drive_btn(B_SS);
    reset_i = 1'b1;
    @(posedge clk);
    #1;
    chk("hold_rst_lap", {lap_hour_o, lap_min_o, lap_sec_o}, 0);
    @(posedge clk);
    #2;
    reset_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("hold_state", state_o, 0);
    chk("hold_ss",    start_stop, 0);
    step(B_NO);
    chk("hold_rel_state", state_o, 0);
    step(B_SS);
    chk("hold_press_state", state_o, 1);
    chk("hold_press_ss",    start_stop, 1);
    step(B_NO);

    // Reset on the first Timeset cycle abandons the load.
    reset_i = 1'b1;
    @(posedge clk);
    #1;
    reset_i = 1'b0;
    hour_i = 5'd5; min_i = 6'd6; sec_i = 6'd7;
    step(B_NO);
    for (int k = 0; k < 4; k++) begin
      step(B_MD);
      step(B_NO);
    end
    chk("ld_pre_state", state_o, 4);
    chk("ld_pre_ts",    Timeset, 1);
    chk("ld_pre_hset",  Hourset, 5);
    #2;
    reset_i = 1'b1;
    #1;
    chk("ld_rst_ts",    Timeset, 0);
    chk("ld_rst_state", state_o, 0);
    chk("ld_rst_shadow", {Hourset, Minset, Secset}, 0);
    @(posedge clk);
    #1;
    reset_i = 1'b0;
    step(B_NO);
    step(B_NO);
    chk("ld_after_state", state_o, 0);
    chk("ld_after_ts",    Timeset, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
